coeff_loader32: RTL and testbench
=================================

Name: coeff_loader32

Overview:
- Write-side counterpart of the 32:1 coefficient selector in the neural-network datapath.
- Accepts a stream of signed coefficients over a valid/ready handshake and distributes them 1-to-32 into a coefficient register bank.
- Also supports single-word addressed writes to the bank.
- The bank drives the 32 coeffNN inputs of the selector, so the selector reads what this block writes.

Parameters:
- Width, 3, bit width of each signed coefficient.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  one-cycle pulse that begins or restarts a full 32-word sequential load.
- inCoeff  input  Width  signed coefficient data, shared by stream and addressed writes.
- inValid  input  1  stream word valid.
- inReady  output  1  block accepts a stream word this cycle.
- WE  input  1  addressed single-word write strobe.
- WADDR  input  5  target index for addressed write.
- coeffBank  output  32*Width  register bank; coeffNN occupies bits [NN*Width +: Width].
- PTR  output  5  index the next stream word will be written to.
- BUSY  output  1  sequential load in progress.
- LOADED  output  1  all 32 words written since last START.

Behaviour:
- Reset (RST_N low, asynchronous): all 32 bank registers = 0; PTR = 0; state = IDLE; inReady = 0; BUSY = 0; LOADED = 0. Reset asserted mid-load discards the load; no partial state survives.
- States:
  - IDLE: inReady = 0, BUSY = 0. START goes to LOAD with PTR = 0.
  - LOAD: inReady = 1, BUSY = 1.
  - DONE: inReady = 0, BUSY = 0, LOADED = 1. START goes to LOAD, PTR = 0, LOADED = 0.
- inReady is a registered function of state only. It never depends combinationally on inValid.
- Stream accept: in LOAD, on an edge where inValid and inReady are both 1:
  - bank[PTR] <= inCoeff.
  - If PTR = 31: PTR wraps to 0 and state goes to DONE.
  - Otherwise PTR increments by 1.
- Accepted word timing: visible on coeffBank in the cycle after the accepting edge (1-cycle latency).
- inValid = 0 in LOAD: no write; PTR holds. Stalls of any length are legal.
- inValid in IDLE or DONE: ignored; no write.
- START while in LOAD (abort/restart): PTR <= 0, stay in LOAD. A word presented on the same edge is NOT written. Bank contents are kept, not cleared.
- START in IDLE or DONE: takes effect on the next edge. PTR = 0 and inReady = 1 in the following cycle.
- Addressed write: on an edge in IDLE or DONE with WE = 1, bank[WADDR] <= inCoeff. State, PTR and LOADED are unchanged.
- WE in LOAD: ignored; the stream has priority.
- WE and START on the same edge in IDLE/DONE: START wins; WE is ignored.
- Data is stored bit-exact as signed Width bits. No extension, no truncation, no arithmetic.
- Untouched bank entries hold their value indefinitely.
- WADDR covers all 32 indices; there is no illegal address.

Test Plan:
- Reset check: assert RST_N = 0 mid-cycle -> coeffBank = 0, PTR = 0, inReady = 0, LOADED = 0 immediately, without waiting for a clock edge.
- Full stream load (Width = 3): pulse START, stream values k mod 8 for k = 0..31 with inValid held high -> 32 accepts. LOADED = 1 and inReady = 0 on the cycle after the 32nd accept. coeff05 = 3'b101, coeff31 = 3'b111, PTR = 0.
- Backpressure and stalls: in LOAD, toggle inValid randomly -> PTR advances only on valid edges. Bank ordering matches the accepted sequence. inValid while in DONE leaves coeffBank unchanged.
- Restart mid-load: after 10 accepts, assert START together with inValid and inCoeff = 3'b011 -> PTR = 0. bank[10] is not written. coeff00..coeff09 retain their earlier values. The next accepted word lands in coeff00.
- Addressed write: in DONE, WE = 1, WADDR = 17, inCoeff = 3'b110 -> only coeff17 changes, LOADED stays 1. Repeat with WE during LOAD -> no change. WE together with START in DONE -> enters LOAD, coeff17 unchanged.
- Mux loopback: connect coeffBank to the 32:1 selector and sweep SEL 0..31 after a load -> outMUX equals each written value in order.

Source files
------------

// File: rtl/coeff_loader32.sv
// rtl/coeff_loader32.sv - streaming / addressed loader for the 32-entry coefficient bank
//
// Fills a 32 x Width register bank. Words can arrive sequentially over a
// valid/ready stream, or one at a time through an addressed write.
// The bank feeds the 32 coefficient inputs of the 32:1 selector.
//
// Ports:
//   CLK        in   system clock; all state changes on the rising edge
//   RST_N      in   asynchronous active-low reset
//   START      in   pulse that begins or restarts a full 32-word sequential load
//   inCoeff    in   signed coefficient; shared by stream and addressed writes
//   inValid    in   stream word valid
//   inReady    out  a stream word is accepted this cycle (registered, state-only)
//   WE         in   addressed write strobe (honoured only outside a load)
//   WADDR      in   addressed write index
//   coeffBank  out  bank contents; entry NN sits at [NN*Width +: Width]
//   PTR        out  index the next stream word will be written to
//   BUSY       out  sequential load in progress
//   LOADED     out  all 32 words have been streamed in since the last START
module coeff_loader32 #(
    parameter int Width = 3
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [Width-1:0]      inCoeff,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic                  WE,
    input  logic [4:0]            WADDR,
    output logic [32*Width-1:0]   coeffBank,
    output logic [4:0]            PTR,
    output logic                  BUSY,
    output logic                  LOADED
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [Width-1:0] bank [32];

    // inReady, BUSY and LOADED are registered alongside the state so that
    // inReady never has a combinational path from inValid.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 32; i++) begin
                bank[i] <= '0;
            end
            PTR     <= 5'd0;
            state   <= IDLE;
            inReady <= 1'b0;
            BUSY    <= 1'b0;
            LOADED  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (START) begin
                        // START has priority over a coincident addressed write
                        state   <= LOAD;
                        PTR     <= 5'd0;
                        inReady <= 1'b1;
                        BUSY    <= 1'b1;
                        LOADED  <= 1'b0;
                    end else if (WE) begin
                        bank[WADDR] <= inCoeff;
                    end
                end
                LOAD: begin
                    if (START) begin
                        // Restart: rewind only; a word offered on this edge is
                        // dropped and existing bank contents are kept.
                        PTR <= 5'd0;
                    end else if (inValid && inReady) begin
                        bank[PTR] <= inCoeff;
                        if (PTR == 5'd31) begin
                            PTR     <= 5'd0;
                            state   <= DONE;
                            inReady <= 1'b0;
                            BUSY    <= 1'b0;
                            LOADED  <= 1'b1;
                        end else begin
                            PTR <= PTR + 5'd1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    inReady <= 1'b0;
                    BUSY    <= 1'b0;
                    LOADED  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < 32; g++) begin : g_pack
        assign coeffBank[g*Width +: Width] = bank[g];
    end

endmodule

// File: tb/tb_coeff_loader32.sv
// tb/tb_coeff_loader32.sv - scoreboard bench for coeff_loader32
module tb_coeff_loader32;

    localparam int W = 3;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic            START = 1'b0;
    logic [W-1:0]    inCoeff = '0;
    logic            inValid = 1'b0;
    logic            inReady;
    logic            WE = 1'b0;
    logic [4:0]      WADDR = '0;
    logic [32*W-1:0] coeffBank;
    logic [4:0]      PTR;
    logic            BUSY;
    logic            LOADED;

    coeff_loader32 #(.Width(W)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .inCoeff(inCoeff),
        .inValid(inValid), .inReady(inReady), .WE(WE), .WADDR(WADDR),
        .coeffBank(coeffBank), .PTR(PTR), .BUSY(BUSY), .LOADED(LOADED)
    );

    always #5 CLK = ~CLK;

    // kind: 0 coeff[idx], 1 PTR, 2 inReady, 3 BUSY, 4 LOADED, 5 whole bank
    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [95:0] exp;
    } chk_t;

    chk_t q[$];
    int   total = 0;
    int   bad = 0;
    event chk_ev;

    function automatic logic [95:0] actual(int kind, int idx);
        case (kind)
            0: return {93'b0, coeffBank[idx*W +: W]};
            1: return {91'b0, PTR};
            2: return {95'b0, inReady};
            3: return {95'b0, BUSY};
            4: return {95'b0, LOADED};
            default: return coeffBank;
        endcase
    endfunction

    task automatic push(input string name, input int kind, input int idx, input logic [95:0] exp);
        chk_t c;
        c.name = name; c.kind = kind; c.idx = idx; c.exp = exp;
        q.push_back(c);
    endtask

    task automatic push_reset_state(input string tag);
        push({tag, "_bank"}, 5, 0, 96'd0);
        push({tag, "_ptr"}, 1, 0, 96'd0);
        push({tag, "_ready"}, 2, 0, 96'd0);
        push({tag, "_busy"}, 3, 0, 96'd0);
        push({tag, "_loaded"}, 4, 0, 96'd0);
    endtask

    // Monitor: drains pending expectations at each falling edge, or on demand
    // for checks that must happen between clock edges.
    initial begin
        forever begin
            @(negedge CLK or chk_ev);
            while (q.size() > 0) begin
                chk_t c;
                logic [95:0] a;
                c = q.pop_front();
                a = actual(c.kind, c.idx);
                total++;
                if (a !== c.exp) begin
                    bad++;
                    $display("FAIL %s idx=%0d: got %0h want %0h", c.name, c.idx, a, c.exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    int n;
    logic [31:0] vpat;
    logic [2:0]  first[10];

    initial begin
        // Reset state
        step();
        step();
        push_reset_state("rst0");
        step();
        RST_N = 1'b1;
        step();

        // Full stream load of k mod 8
        START = 1'b1;
        step();
        START = 1'b0;
        push("load_ready", 2, 0, 96'd1);
        push("load_busy", 3, 0, 96'd1);
        push("load_ptr0", 1, 0, 96'd0);
        for (int k = 0; k < 32; k++) begin
            inValid = 1'b1;
            inCoeff = 3'(k % 8);
            step();
        end
        inValid = 1'b0;
        push("full_loaded", 4, 0, 96'd1);
        push("full_ready", 2, 0, 96'd0);
        push("full_busy", 3, 0, 96'd0);
        push("full_ptr", 1, 0, 96'd0);
        push("coeff05", 0, 5, 96'h5);
        push("coeff31", 0, 31, 96'h7);

        // inValid in DONE must not write
        inValid = 1'b1;
        inCoeff = 3'b010;
        step();
        step();
        inValid = 1'b0;
        for (int k = 0; k < 32; k++) push("done_hold", 0, k, 96'(k % 8));

        // Addressed write in DONE
        WE = 1'b1; WADDR = 5'd17; inCoeff = 3'b110;
        step();
        WE = 1'b0;
        push("aw_c17", 0, 17, 96'h6);
        push("aw_c16", 0, 16, 96'h0);
        push("aw_c18", 0, 18, 96'h2);
        push("aw_loaded", 4, 0, 96'd1);
        push("aw_ptr", 1, 0, 96'd0);

        // WE together with START in DONE: START wins
        START = 1'b1; WE = 1'b1; WADDR = 5'd17; inCoeff = 3'b001;
        step();
        START = 1'b0; WE = 1'b0;
        push("ws_ready", 2, 0, 96'd1);
        push("ws_busy", 3, 0, 96'd1);
        push("ws_loaded", 4, 0, 96'd0);
        push("ws_c17", 0, 17, 96'h6);
        push("ws_ptr", 1, 0, 96'd0);

        // Stalled stream: PTR advances only on valid cycles
        vpat = 32'hA5C3_96E1;
        n = 0;
        for (int c = 0; c < 32 && n < 10; c++) begin
            inValid = vpat[c];
            inCoeff = 3'((n * 3 + 1) % 8);
            if (vpat[c]) begin
                first[n] = 3'((n * 3 + 1) % 8);
                n++;
            end
            step();
            push("stall_ptr", 1, 0, 96'(n));
        end
        inValid = 1'b0;

        // WE during LOAD is ignored
        WE = 1'b1; WADDR = 5'd20; inCoeff = 3'b001;
        step();
        WE = 1'b0;
        push("we_load_c20", 0, 20, 96'h4);
        push("we_load_ptr", 1, 0, 96'd10);

        // Restart mid-load with a word on the same edge
        START = 1'b1; inValid = 1'b1; inCoeff = 3'b011;
        step();
        START = 1'b0;
        push("rs_ptr", 1, 0, 96'd0);
        push("rs_c10", 0, 10, 96'h2);
        push("rs_ready", 2, 0, 96'd1);
        for (int k = 0; k < 10; k++) push("rs_keep", 0, k, 96'(first[k]));

        // Complete the second load with (k+5) mod 8
        for (int k = 0; k < 32; k++) begin
            inCoeff = 3'((k + 5) % 8);
            step();
            if (k == 0) begin
                push("rs_next_c00", 0, 0, 96'h5);
                push("rs_next_ptr", 1, 0, 96'd1);
            end
        end
        inValid = 1'b0;
        push("load2_loaded", 4, 0, 96'd1);

        // Selector loopback: sweep SEL over the bank
        for (int s = 0; s < 32; s++) push("mux_sel", 0, s, 96'((s + 5) % 8));
        step();

        // Asynchronous reset in the middle of a load
        START = 1'b1;
        step();
        START = 1'b0;
        inValid = 1'b1; inCoeff = 3'b111;
        repeat (5) step();
        #2;
        RST_N = 1'b0;
        #1;
        push_reset_state("rst_async");
        ->chk_ev;
        inValid = 1'b0;
        step();
        RST_N = 1'b1;
        step();
        push_reset_state("rst_after");
        step();

        for (int t = 0; t < 10 && q.size() > 0; t++) step();
        if (q.size() > 0) begin
            $display("FAIL drain: got %0d pending want 0", q.size());
            total++;
            bad++;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
